// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: start/serve/play/point/over flow, BCD scoring and winner detection.
// Gates the ball/paddle engine via run_en and commands re-centering and serve direction.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 100,
  parameter int POINT_TICKS = 50,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_1,
  input  logic       miss_2,
  output logic       run_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_1_ones,
  output logic [3:0] score_1_tens,
  output logic [3:0] score_2_ones,
  output logic [3:0] score_2_tens,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_dly_q;
  logic [3:0]       s1_ones_q, s1_ones_d, s1_tens_q, s1_tens_d;
  logic [3:0]       s2_ones_q, s2_ones_d, s2_tens_q, s2_tens_d;
  logic [1:0]       winner_q, winner_d;
  logic [1:0]       win_pend_q, win_pend_d;
  logic             serve_dir_q, serve_dir_d;
  logic             ball_reset_q, ball_reset_d;

  logic             adv;
  logic             start_rise;
  logic [7:0]       p1_inc, p2_inc;

  // BCD increment of a two-digit score; 99 saturates.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones == 4'd9) begin
      if (tens == 4'd9) r = {tens, ones};
      else              r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd_val(input logic [7:0] bcd);
    return ({3'd0, bcd[7:4]} * 7'd10) + {3'd0, bcd[3:0]};
  endfunction

  assign adv        = tick & ~pause;
  assign start_rise = start & ~start_dly_q;
  assign p1_inc     = bcd_inc(s1_tens_q, s1_ones_q);
  assign p2_inc     = bcd_inc(s2_tens_q, s2_ones_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_ones_d   = s1_ones_q;
    s1_tens_d   = s1_tens_q;
    s2_ones_d   = s2_ones_q;
    s2_tens_d   = s2_tens_q;
    winner_d    = winner_q;
    win_pend_d  = win_pend_q;
    serve_dir_d = serve_dir_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          s1_ones_d   = 4'd0;
          s1_tens_d   = 4'd0;
          s2_ones_d   = 4'd0;
          s2_tens_d   = 4'd0;
          winner_d    = 2'b00;
          win_pend_d  = 2'b00;
          serve_dir_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_SERVE;
        end
      end

      S_SERVE: begin
        if (adv) begin
          if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_PLAY: begin
        if (adv && (miss_1 || miss_2)) begin
          cnt_d   = '0;
          state_d = S_POINT;
          // A double miss is a dead ball: nobody scores, serve side is kept.
          if (miss_1 && !miss_2) begin
            {s2_tens_d, s2_ones_d} = p2_inc;
            serve_dir_d            = 1'b0;
            if (bcd_val(p2_inc) == 7'(WIN_SCORE)) win_pend_d = 2'b10;
          end else if (miss_2 && !miss_1) begin
            {s1_tens_d, s1_ones_d} = p1_inc;
            serve_dir_d            = 1'b1;
            if (bcd_val(p1_inc) == 7'(WIN_SCORE)) win_pend_d = 2'b01;
          end
        end
      end

      S_POINT: begin
        if (win_pend_q != 2'b00) begin
          winner_d   = win_pend_q;
          win_pend_d = 2'b00;
          state_d    = S_OVER;
        end else if (adv) begin
          if (cnt_q == CNT_W'(POINT_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = S_SERVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    ball_reset_d = (state_d == S_SERVE) && (state_q != S_SERVE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_dly_q  <= 1'b0;
      s1_ones_q    <= 4'd0;
      s1_tens_q    <= 4'd0;
      s2_ones_q    <= 4'd0;
      s2_tens_q    <= 4'd0;
      winner_q     <= 2'b00;
      win_pend_q   <= 2'b00;
      serve_dir_q  <= 1'b0;
      ball_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_dly_q  <= start;
      s1_ones_q    <= s1_ones_d;
      s1_tens_q    <= s1_tens_d;
      s2_ones_q    <= s2_ones_d;
      s2_tens_q    <= s2_tens_d;
      winner_q     <= winner_d;
      win_pend_q   <= win_pend_d;
      serve_dir_q  <= serve_dir_d;
      ball_reset_q <= ball_reset_d;
    end
  end

  assign run_en       = (state_q == S_PLAY) && !pause;
  assign ball_reset   = ball_reset_q;
  assign serve_dir    = serve_dir_q;
  assign score_1_ones = s1_ones_q;
  assign score_1_tens = s1_tens_q;
  assign score_2_ones = s2_ones_q;
  assign score_2_tens = s2_tens_q;
  assign winner       = winner_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: serve timing, scoring, BCD carry, win, pause, async reset.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       miss_1 = 1'b0;
  logic       miss_2 = 1'b0;
  logic       run_en, ball_reset, serve_dir;
  logic [3:0] score_1_ones, score_1_tens, score_2_ones, score_2_tens;
  logic [1:0] winner;
  logic [2:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;

  pong_match_ctrl #(
    .WIN_SCORE(11), .SERVE_TICKS(100), .POINT_TICKS(50), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause),
    .miss_1(miss_1), .miss_2(miss_2), .run_en(run_en), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score_1_ones(score_1_ones), .score_1_tens(score_1_tens),
    .score_2_ones(score_2_ones), .score_2_tens(score_2_tens), .winner(winner),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic m1, input logic m2);
    tick = 1'b1; miss_1 = m1; miss_2 = m2;
    step();
    tick = 1'b0; miss_1 = 1'b0; miss_2 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0, 1'b0);
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_state", state_o, 0);
    chk("rst_run_en", run_en, 0);
    chk("rst_ball_reset", ball_reset, 0);
    chk("rst_winner", winner, 0);
    chk("rst_s1", {score_1_tens, score_1_ones}, 0);
    step(); step();
    reset_n = 1'b1;
    step();
    ticks(5);
    chk("idle_no_start", state_o, 0);

    // 1. start -> SERVE, 100 ticks -> PLAY
    press_start();
    chk("start_ball_reset", ball_reset, 1);
    chk("start_state", state_o, 1);
    step();
    chk("ball_reset_1clk", ball_reset, 0);
    ticks(99);
    chk("serve_99", state_o, 1);
    chk("serve_run_en", run_en, 0);
    do_tick(1'b0, 1'b0);
    chk("serve_100_play", state_o, 2);
    chk("play_run_en", run_en, 1);

    // 2. single point for player 1
    do_tick(1'b0, 1'b1);
    chk("pt_s1_ones", score_1_ones, 1);
    chk("pt_serve_dir", serve_dir, 1);
    chk("pt_state", state_o, 3);
    chk("pt_run_en", run_en, 0);
    step();
    chk("pt_hold", state_o, 3);
    ticks(49);
    chk("pt_49", state_o, 3);
    chk("pt_49_no_br", ball_reset, 0);
    do_tick(1'b0, 1'b0);
    chk("pt_50_br", ball_reset, 1);
    chk("pt_50_serve", state_o, 1);
    step();
    chk("pt_br_clear", ball_reset, 0);

    // 3. player 2 scores 11 with BCD carry
    for (int p = 1; p <= 11; p++) begin
      ticks(100);
      do_tick(1'b1, 1'b0);
      if (p == 9) begin
        chk("p2_9_ones", score_2_ones, 9);
        chk("p2_9_tens", score_2_tens, 0);
      end
      if (p == 10) begin
        chk("p2_10_ones", score_2_ones, 0);
        chk("p2_10_tens", score_2_tens, 1);
      end
      if (p < 11) ticks(50);
    end
    chk("p2_11", {score_2_tens, score_2_ones}, 8'h11);
    chk("p2_11_serve_dir", serve_dir, 0);
    chk("p2_11_point", state_o, 3);
    step();
    chk("over_state", state_o, 4);
    chk("over_winner", winner, 2);
    chk("over_run_en", run_en, 0);
    do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b1);
    chk("over_s2_hold", {score_2_tens, score_2_ones}, 8'h11);
    chk("over_s1_hold", {score_1_tens, score_1_ones}, 8'h01);
    chk("over_state_hold", state_o, 4);

    // Restart from OVER
    press_start();
    chk("restart_state", state_o, 1);
    chk("restart_br", ball_reset, 1);
    chk("restart_winner", winner, 0);
    chk("restart_s2", {score_2_tens, score_2_ones}, 0);
    chk("restart_s1", {score_1_tens, score_1_ones}, 0);

    // 4. simultaneous miss after a p1 point sets serve_dir = 1
    ticks(100);
    do_tick(1'b0, 1'b1);
    ticks(50);
    ticks(100);
    chk("sim_pre_play", state_o, 2);
    do_tick(1'b1, 1'b1);
    chk("sim_state", state_o, 3);
    chk("sim_s1", {score_1_tens, score_1_ones}, 8'h01);
    chk("sim_s2", {score_2_tens, score_2_ones}, 0);
    chk("sim_serve_dir", serve_dir, 1);

    // 5. pause in PLAY with miss_1 held
    ticks(50);
    ticks(100);
    pause = 1'b1;
    #1;
    chk("pause_run_en", run_en, 0);
    for (int i = 0; i < 30; i++) do_tick(1'b1, 1'b0);
    chk("pause_state", state_o, 2);
    chk("pause_s2", {score_2_tens, score_2_ones}, 0);
    pause = 1'b0;
    #1;
    chk("unpause_run_en", run_en, 1);
    do_tick(1'b1, 1'b0);
    chk("unpause_s2", score_2_ones, 1);
    chk("unpause_state", state_o, 3);

    // 6. async reset mid-POINT, between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_s1", score_1_ones, 0);
    chk("arst_s2", score_2_ones, 0);
    chk("arst_run_en", run_en, 0);
    chk("arst_winner", winner, 0);
    step();
    reset_n = 1'b1;
    ticks(60);
    chk("arst_idle_wait", state_o, 0);
    press_start();
    chk("arst_restart", state_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1);
  end

endmodule
